// File: rtl/pixel_rst_seq_if.sv
// Status/control bundle between the pixel-clock reset sequencer and its environment.
// The slave side is the sequencer. The master side drives `locked` and observes the reset, enable and loss status.
interface pixel_rst_seq_if #(
  parameter int CNT_W = 8
);
  logic             locked;
  logic             rst_pix;
  logic             pix_en;
  logic             lock_lost;
  logic [CNT_W-1:0] lock_loss_cnt;

  modport master (
    output locked,
    input  rst_pix,
    input  pix_en,
    input  lock_lost,
    input  lock_loss_cnt
  );

  modport slave (
    input  locked,
    output rst_pix,
    output pix_en,
    output lock_lost,
    output lock_loss_cnt
  );
endinterface

// File: rtl/pixel_rst_seq.sv
// Pixel-domain reset sequencer: synchronises MMCM lock, releases rst_pix after stable lock, then raises pix_en.
// Optional lock-loss counter is built only when PIXEL_RST_LOSS_CNT_EN is defined.
//
// state   | meaning
// HOLD    | pixel domain in reset, waiting for synchronised lock
// STABLE  | lock seen, qualifying LOCK_CYCLES of continuous lock
// RELEASE | rst_pix released, waiting RELEASE_CYCLES before enable
// RUN     | pixel logic enabled
module pixel_rst_seq #(
  parameter int SYNC_STAGES    = 2,
  parameter int LOCK_CYCLES    = 1024,
  parameter int RELEASE_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic           clk_25m,
  input  logic           reset,
  pixel_rst_seq_if.slave bus
);

  localparam int MAX_DWELL = (LOCK_CYCLES > RELEASE_CYCLES) ? LOCK_CYCLES : RELEASE_CYCLES;
  localparam int CW        = $clog2(MAX_DWELL + 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] REL_LAST  = CW'(RELEASE_CYCLES - 1);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STABLE  = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  logic                   rst_pix_q, rst_pix_d;
  logic                   pix_en_q, pix_en_d;
  logic                   lock_lost_q, lock_lost_d;
  logic                   lost_evt;

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_25m or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.locked};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lost_evt = 1'b0;
    case (state_q)
      HOLD: begin
        if (locked_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_d = HOLD;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RELEASE: begin
        if (!locked_s) begin
          state_d  = HOLD;
          lost_evt = 1'b1;
        end else if (cnt_q == REL_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d  = HOLD;
          lost_evt = 1'b1;
        end
      end
      default: state_d = HOLD;
    endcase
    // Outputs are decoded from the next state so they move on the same edge as the state.
    rst_pix_d   = (state_d == HOLD) || (state_d == STABLE);
    pix_en_d    = (state_d == RUN);
    lock_lost_d = lock_lost_q | lost_evt;
  end

  always_ff @(posedge clk_25m or posedge reset) begin
    if (reset) begin
      state_q     <= HOLD;
      cnt_q       <= '0;
      rst_pix_q   <= 1'b1;
      pix_en_q    <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rst_pix_q   <= rst_pix_d;
      pix_en_q    <= pix_en_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign bus.rst_pix   = rst_pix_q;
  assign bus.pix_en    = pix_en_q;
  assign bus.lock_lost = lock_lost_q;

`ifdef PIXEL_RST_LOSS_CNT_EN
  logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (lost_evt && (loss_cnt_q != '1)) begin
      loss_cnt_d = loss_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_25m or posedge reset) begin
    if (reset) begin
      loss_cnt_q <= '0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign bus.lock_loss_cnt = loss_cnt_q;
`else
  assign bus.lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pixel_rst_seq.sv
// Scoreboard bench for pixel_rst_seq: expected output snapshots are queued per clock edge as stimulus is driven.
module tb_pixel_rst_seq;

  localparam int CNT_W = 2;
`ifdef PIXEL_RST_LOSS_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk_25m = 1'b0;
  logic reset   = 1'b1;
  int   cyc     = 0;
  int   errors  = 0;
  int   checks  = 0;

  pixel_rst_seq_if #(.CNT_W(CNT_W)) bus ();

  pixel_rst_seq #(
    .SYNC_STAGES   (2),
    .LOCK_CYCLES   (8),
    .RELEASE_CYCLES(4),
    .CNT_W         (CNT_W)
  ) dut (
    .clk_25m(clk_25m),
    .reset  (reset),
    .bus    (bus)
  );

  always #20 clk_25m = ~clk_25m;
  always @(posedge clk_25m) cyc++;

  typedef struct {
    int    cyc;
    string tag;
    logic  rst;
    logic  en;
    logic  lost;
    int    cnt;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push(input int at, input string tag, input logic r, input logic e,
                      input logic l, input int c);
    exp_t x;
    x.cyc = at; x.tag = tag; x.rst = r; x.en = e; x.lost = l; x.cnt = c;
    sb.push_back(x);
  endtask

  // Compare every queued snapshot whose edge has been reached.
  always @(negedge clk_25m) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        check({e.tag, "_late"}, 32'(cyc), 32'(e.cyc));
      end else begin
        check({e.tag, "_rst"},  32'(bus.rst_pix),       32'(e.rst));
        check({e.tag, "_en"},   32'(bus.pix_en),        32'(e.en));
        check({e.tag, "_lost"}, 32'(bus.lock_lost),     32'(e.lost));
        check({e.tag, "_cnt"},  32'(bus.lock_loss_cnt), 32'(e.cnt));
      end
    end
  end

  task automatic drain(input string tag);
    int guard = 0;
    while (sb.size() > 0 && guard < 200) begin
      @(negedge clk_25m);
      guard++;
    end
    @(negedge clk_25m);
    if (sb.size() > 0) begin
      check({tag, "_timeout"}, 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rst"},  32'(bus.rst_pix),       32'd1);
    check({tag, "_en"},   32'(bus.pix_en),        32'd0);
    check({tag, "_lost"}, 32'(bus.lock_lost),     32'd0);
    check({tag, "_cnt"},  32'(bus.lock_loss_cnt), 32'd0);
  endtask

  // Called on a negedge with locked_s low and the FSM in HOLD.
  task automatic relock(input string tag, input logic l, input int c);
    int c0 = cyc;
    bus.locked = 1'b1;
    push(c0 + 10, {tag, "_pre_rel"}, 1'b1, 1'b0, l, c);
    push(c0 + 11, {tag, "_rel"},     1'b0, 1'b0, l, c);
    push(c0 + 14, {tag, "_pre_en"},  1'b0, 1'b0, l, c);
    push(c0 + 15, {tag, "_en"},      1'b0, 1'b1, l, c);
    drain(tag);
  endtask

  // Called on a negedge while in RUN.
  task automatic drop(input string tag, input logic l_before, input int c_before, input int c_after);
    int c0 = cyc;
    bus.locked = 1'b0;
    push(c0 + 2, {tag, "_still_run"}, 1'b0, 1'b1, l_before, c_before);
    push(c0 + 3, {tag, "_hold"},      1'b1, 1'b0, 1'b1,     c_after);
    drain(tag);
    repeat (3) @(negedge clk_25m);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   c0;
    logic exp_lost;
    int   exp_cnt;
    int   nxt;

    bus.locked = 1'b0;
    repeat (3) @(negedge clk_25m);
    check_reset_vals("por");
    reset = 1'b0;
    repeat (2) @(negedge clk_25m);
    check_reset_vals("hold_unlocked");

    relock("s1", 1'b0, 0);

    exp_lost = 1'b0;
    exp_cnt  = 0;
    for (int i = 0; i < 5; i++) begin
      nxt = CNT_EN ? ((exp_cnt < 3) ? exp_cnt + 1 : 3) : 0;
      drop($sformatf("loss%0d", i), exp_lost, exp_cnt, nxt);
      exp_lost = 1'b1;
      exp_cnt  = nxt;
      relock($sformatf("relock%0d", i), exp_lost, exp_cnt);
    end

    // Asynchronous reset in RUN, away from any clock edge.
    @(negedge clk_25m);
    #5;
    reset = 1'b1;
    #1;
    check_reset_vals("async_rst");
    @(negedge clk_25m);
    check_reset_vals("rst_held");
    bus.locked = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk_25m);

    // Short lock pulse must not release reset.
    c0 = cyc;
    bus.locked = 1'b1;
    push(c0 + 4, "s2_stable", 1'b1, 1'b0, 1'b0, 0);
    push(c0 + 7, "s2_late",   1'b1, 1'b0, 1'b0, 0);
    push(c0 + 8, "s2_hold",   1'b1, 1'b0, 1'b0, 0);
    repeat (5) @(negedge clk_25m);
    bus.locked = 1'b0;
    repeat (3) @(negedge clk_25m);
    relock("s2", 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
